word_loader: RTL and testbench

- Consumer end of the toggle data bank: takes the 16-bit toggle word, commits it into a small on-chip word store on a Load press, then pulses the bank's synchronous clear.
- Provides step-through read-back of stored words for the display/LED path.
- Clocked by the same manual clock as the button logic; all button inputs are raw and edge-detected internally.

---
 rtl/word_loader.sv | 80 ++++++++
 tb/tb_word_loader.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/word_loader.sv
// word_loader: commits the toggle-bank word into a small store on Load, pulses the bank clear,
// and offers step-through read-back of the stored words.
module word_loader #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             load_btn,
  input  logic             next_btn,
  input  logic             erase_btn,
  input  logic [WIDTH-1:0] data_in,
  output logic             clear,
  output logic [WIDTH-1:0] rd_data,
  output logic [PTR_W-1:0] rd_addr,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty,
  output logic             overflow
);
  typedef enum logic [1:0] {IDLE, WRITE, CLEAR, ERASE} state_t;
  state_t state;
  logic [2:0] q1, q2;
  logic ld_p, nx_p, er_p;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0] rd_nxt;
  assign {er_p, nx_p, ld_p} = q1 & ~q2;
  assign rd_nxt = {1'b0, rd_ptr} + (PTR_W+1)'(1);
  assign full = count == (PTR_W+1)'(DEPTH);
  assign empty = count == '0;
  assign rd_addr = rd_ptr;
  assign rd_data = empty ? '0 : mem[rd_ptr];
  // Erase only resets pointers; stale words stay hidden behind the empty mask.
  always_ff @(posedge clk or negedge nRST)
    if (!nRST) begin
      state <= IDLE;
      clear <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      q1 <= '0;
      q2 <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      q1 <= {erase_btn, next_btn, load_btn};
      q2 <= q1;
      if (nx_p && !empty) rd_ptr <= rd_nxt == count ? '0 : rd_nxt[PTR_W-1:0];
      case (state)
        IDLE: begin
          if (er_p) begin
            state <= ERASE;
            clear <= 1'b1;
          end else if (ld_p && !full) state <= WRITE;
          else if (ld_p) overflow <= 1'b1;
        end
        WRITE: begin
          mem[wr_ptr] <= data_in;
          wr_ptr <= wr_ptr + PTR_W'(1);
          count <= count + (PTR_W+1)'(1);
          state <= CLEAR;
          clear <= 1'b1;
        end
        CLEAR: begin
          state <= IDLE;
          clear <= 1'b0;
        end
        default: begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          count <= '0;
          overflow <= 1'b0;
          state <= IDLE;
          clear <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_word_loader.sv
// tb_word_loader: table-driven checks of load/next/erase with a queue of stored words for read-back.
module tb_word_loader;
  logic clk = 0, nRST = 0, load_btn = 0, next_btn = 0, erase_btn = 0;
  logic [15:0] data_in = 0, rd_data;
  logic [2:0] rd_addr;
  logic [3:0] count;
  logic clear, full, empty, overflow;
  int errors = 0, checks = 0;
  logic [15:0] sb [$];

  word_loader #(.WIDTH(16), .DEPTH(8)) dut (
    .clk(clk), .nRST(nRST), .load_btn(load_btn), .next_btn(next_btn), .erase_btn(erase_btn),
    .data_in(data_in), .clear(clear), .rd_data(rd_data), .rd_addr(rd_addr), .count(count),
    .full(full), .empty(empty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] b;
    logic [15:0] d;
    logic [3:0] cnt;
    logic [2:0] addr;
    logic [15:0] rd;
    logic f, e, o;
    int nclr, first;
  } vec_t;
  vec_t tbl [$];

  localparam logic [2:0] L = 3'b001, N = 3'b010, E = 3'b100, W = 3'b111;

  function automatic vec_t v(logic [2:0] b, logic [15:0] d, int cnt, int addr, logic [15:0] rd,
                             logic f, logic e, logic o, int nclr, int first);
    vec_t r;
    r.b = b; r.d = d; r.cnt = 4'(cnt); r.addr = 3'(addr); r.rd = rd;
    r.f = f; r.e = e; r.o = o; r.nclr = nclr; r.first = first;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive a one-cycle button press at a negedge and watch clear over the following cycles.
  task automatic press(input logic [2:0] b, input logic [15:0] d, output int nclr, output int first);
    logic prev;
    data_in = d;
    {erase_btn, next_btn, load_btn} = b;
    nclr = 0; first = 0; prev = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) {erase_btn, next_btn, load_btn} = 3'b000;
      if (clear) begin
        nclr++;
        if (first == 0) first = i;
        chk("clear_consecutive", prev, 0);
      end
      prev = clear;
    end
  endtask

  initial begin
    int nclr, first;
    // Reset with Load held across the release
    load_btn = 1; data_in = 16'h1111;
    repeat (2) @(negedge clk);
    chk("rst rd_data", rd_data, 0);
    chk("rst count", count, 0);
    chk("rst empty", empty, 1);
    chk("rst full", full, 0);
    chk("rst clear", clear, 0);
    chk("rst overflow", overflow, 0);
    chk("rst rd_addr", rd_addr, 0);
    nRST = 1;
    nclr = 0; first = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (clear) begin nclr++; if (first == 0) first = i; end
    end
    load_btn = 0;
    repeat (2) @(negedge clk);
    chk("held_rst nclr", nclr, 1);
    chk("held_rst latency", first, 3);
    chk("held_rst count", count, 1);
    chk("held_rst rd_data", rd_data, 16'h1111);

    tbl.push_back(v(E, 0, 0, 0, 0, 0, 1, 0, 1, 2));
    tbl.push_back(v(L, 16'hA5C3, 1, 0, 16'hA5C3, 0, 0, 0, 1, 3));
    tbl.push_back(v(E, 0, 0, 0, 0, 0, 1, 0, 1, 2));
    for (int k = 1; k <= 8; k++) tbl.push_back(v(L, 16'(k), k, 0, 16'h0001, k == 8, 0, 0, 1, 3));
    tbl.push_back(v(L, 16'h0009, 8, 0, 16'h0001, 1, 0, 1, 0, 0));
    tbl.push_back(v(W, 0, 8, 0, 16'h0001, 1, 0, 1, 0, 0));
    tbl.push_back(v(E, 0, 0, 0, 0, 0, 1, 0, 1, 2));
    tbl.push_back(v(L, 16'h00A1, 1, 0, 16'h00A1, 0, 0, 0, 1, 3));
    tbl.push_back(v(L, 16'h00A2, 2, 0, 16'h00A1, 0, 0, 0, 1, 3));
    tbl.push_back(v(L, 16'h00A3, 3, 0, 16'h00A1, 0, 0, 0, 1, 3));
    tbl.push_back(v(N, 0, 3, 1, 16'h00A2, 0, 0, 0, 0, 0));
    tbl.push_back(v(N, 0, 3, 2, 16'h00A3, 0, 0, 0, 0, 0));
    tbl.push_back(v(N, 0, 3, 0, 16'h00A1, 0, 0, 0, 0, 0));
    tbl.push_back(v(N, 0, 3, 1, 16'h00A2, 0, 0, 0, 0, 0));
    tbl.push_back(v(L, 16'h00A4, 4, 1, 16'h00A2, 0, 0, 0, 1, 3));
    tbl.push_back(v(L, 16'h00A5, 5, 1, 16'h00A2, 0, 0, 0, 1, 3));
    tbl.push_back(v(E, 0, 0, 0, 0, 0, 1, 0, 1, 2));
    tbl.push_back(v(L, 16'h00C1, 1, 0, 16'h00C1, 0, 0, 0, 1, 3));
    tbl.push_back(v(E, 0, 0, 0, 0, 0, 1, 0, 1, 2));
    tbl.push_back(v(L, 16'h00B1, 1, 0, 16'h00B1, 0, 0, 0, 1, 3));
    tbl.push_back(v(L, 16'h00B2, 2, 0, 16'h00B1, 0, 0, 0, 1, 3));
    tbl.push_back(v(N, 0, 2, 1, 16'h00B2, 0, 0, 0, 0, 0));
    tbl.push_back(v(L | N, 16'h00B3, 3, 0, 16'h00B1, 0, 0, 0, 1, 3));
    tbl.push_back(v(N, 0, 3, 1, 16'h00B2, 0, 0, 0, 0, 0));
    tbl.push_back(v(N, 0, 3, 2, 16'h00B3, 0, 0, 0, 0, 0));
    tbl.push_back(v(E, 0, 0, 0, 0, 0, 1, 0, 1, 2));
    tbl.push_back(v(N, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(v(L, 16'h00EE, 1, 0, 16'h00EE, 0, 0, 0, 1, 3));
    tbl.push_back(v(L | E, 16'h00FF, 0, 0, 0, 0, 1, 0, 1, 2));

    foreach (tbl[i]) begin
      if (tbl[i].b == W) begin
        while (sb.size() > 0) begin
          chk($sformatf("row%0d walk rd_data", i), rd_data, sb.pop_front());
          press(N, 0, nclr, first);
        end
      end else begin
        press(tbl[i].b, tbl[i].d, nclr, first);
        chk($sformatf("row%0d nclr", i), nclr, tbl[i].nclr);
        chk($sformatf("row%0d clear_latency", i), first, tbl[i].first);
        if (tbl[i].b[2]) sb.delete();
        else if (tbl[i].b[0] && tbl[i].nclr == 1) sb.push_back(tbl[i].d);
      end
      chk($sformatf("row%0d count", i), count, tbl[i].cnt);
      chk($sformatf("row%0d rd_addr", i), rd_addr, tbl[i].addr);
      chk($sformatf("row%0d rd_data", i), rd_data, tbl[i].rd);
      chk($sformatf("row%0d full", i), full, tbl[i].f);
      chk($sformatf("row%0d empty", i), empty, tbl[i].e);
      chk($sformatf("row%0d overflow", i), overflow, tbl[i].o);
    end

    // Load held for ten cycles gives a single write
    load_btn = 1; data_in = 16'hD0D0; nclr = 0;
    repeat (10) begin
      @(negedge clk);
      if (clear) nclr++;
    end
    load_btn = 0;
    repeat (4) @(negedge clk);
    chk("hold10 nclr", nclr, 1);
    chk("hold10 count", count, 1);
    chk("hold10 rd_data", rd_data, 16'hD0D0);

    // Reset asserted while in WRITE: write lost, clear low immediately
    load_btn = 1; data_in = 16'h7777;
    @(negedge clk);
    load_btn = 0;
    @(negedge clk);
    #1 nRST = 0;
    #1;
    chk("midrst count", count, 0);
    chk("midrst clear", clear, 0);
    chk("midrst rd_data", rd_data, 0);
    chk("midrst empty", empty, 1);
    @(negedge clk);
    nRST = 1;
    repeat (4) @(negedge clk);
    chk("midrst after count", count, 0);
    chk("midrst after clear", clear, 0);
    chk("midrst after overflow", overflow, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
